// File: rtl/bit_err_counter.sv
// bit_err_counter: counts mismatching bits over FRAME_LEN valid bits and reports a saturating per-frame count.
// Optional sticky threshold alarm (alarm_o, ALARM_THR) is enabled by defining ERR_ALARM_EN.
module bit_err_counter #(
    parameter int FRAME_LEN = 64,
    parameter int CNT_W     = 8
`ifdef ERR_ALARM_EN
    ,
    parameter int ALARM_THR = 4
`endif
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             valid_i,
    input  logic             err_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             sat_o
`ifdef ERR_ALARM_EN
    ,
    output logic             alarm_o
`endif
);
    localparam int BW = $clog2(FRAME_LEN + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    state_e           state_q, state_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx, err_cnt_q, err_cnt_d;
    logic             lsat_q, lsat_d, lsat_nx, sat_q, sat_d, last;
`ifdef ERR_ALARM_EN
    logic             alarm_q, alarm_d;
    assign alarm_o = alarm_q;
`endif
    assign busy_o    = state_q == RUN;
    assign done_o    = state_q == DONE;
    assign err_cnt_o = err_cnt_q;
    assign sat_o     = sat_q;
    // Final count of the bit being accepted this cycle, including its own err_i.
    assign cnt_nx  = (err_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    assign lsat_nx = lsat_q | (err_i & (cnt_q == '1));
    assign last    = bit_q == BW'(FRAME_LEN - 1);
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        cnt_d     = cnt_q;
        lsat_d    = lsat_q;
        err_cnt_d = err_cnt_q;
        sat_d     = sat_q;
`ifdef ERR_ALARM_EN
        alarm_d   = alarm_q;
`endif
        if (start_i) begin
            state_d = RUN;
            bit_d   = '0;
            cnt_d   = '0;
            lsat_d  = 1'b0;
`ifdef ERR_ALARM_EN
            alarm_d = (state_q == RUN) ? alarm_q : 1'b0;
`endif
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end else if (state_q == RUN && valid_i) begin
            bit_d  = bit_q + 1'b1;
            cnt_d  = cnt_nx;
            lsat_d = lsat_nx;
            if (last) begin
                state_d   = DONE;
                err_cnt_d = cnt_nx;
                sat_d     = lsat_nx;
`ifdef ERR_ALARM_EN
                alarm_d   = alarm_q | (int'(cnt_nx) >= ALARM_THR);
`endif
            end
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            bit_q     <= '0;
            cnt_q     <= '0;
            lsat_q    <= 1'b0;
            err_cnt_q <= '0;
            sat_q     <= 1'b0;
`ifdef ERR_ALARM_EN
            alarm_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            cnt_q     <= cnt_d;
            lsat_q    <= lsat_d;
            err_cnt_q <= err_cnt_d;
            sat_q     <= sat_d;
`ifdef ERR_ALARM_EN
            alarm_q   <= alarm_d;
`endif
        end
    end
endmodule

// File: tb/tb_bit_err_counter.sv
// tb_bit_err_counter: scoreboard bench for bit_err_counter; a default instance and a CNT_W=4/FRAME_LEN=32 instance.
module tb_bit_err_counter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, valid = 1'b0, err = 1'b0;
    logic       start4 = 1'b0, valid4 = 1'b0, err4 = 1'b0;
    logic       busy, done, sat, busy4, done4, sat4;
    logic [7:0] cnt;
    logic [3:0] cnt4;
    logic       alarm, alarm4;
    int         checks = 0, errors = 0;
    logic [8:0] q0[$];
    logic [4:0] q4[$];

    always #5 clk = ~clk;

    bit_err_counter u0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .valid_i(valid), .err_i(err),
        .busy_o(busy), .done_o(done), .err_cnt_o(cnt), .sat_o(sat)
`ifdef ERR_ALARM_EN
        , .alarm_o(alarm)
`endif
    );

    bit_err_counter #(.FRAME_LEN(32), .CNT_W(4)) u4 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start4), .valid_i(valid4), .err_i(err4),
        .busy_o(busy4), .done_o(done4), .err_cnt_o(cnt4), .sat_o(sat4)
`ifdef ERR_ALARM_EN
        , .alarm_o(alarm4)
`endif
    );

`ifndef ERR_ALARM_EN
    assign alarm  = 1'b0;
    assign alarm4 = 1'b0;
`endif

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    // Monitors pop the scoreboard whenever an instance reports a completed frame.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q0.size() == 0) chk("u0_unexpected_done", 1, 0);
            else begin
                logic [8:0] x;
                x = q0.pop_front();
                chk("u0_err_cnt", cnt, x[7:0]);
                chk("u0_sat", sat, x[8]);
            end
        end
        if (done4 === 1'b1) begin
            if (q4.size() == 0) chk("u4_unexpected_done", 1, 0);
            else begin
                logic [4:0] y;
                y = q4.pop_front();
                chk("u4_err_cnt", cnt4, y[3:0]);
                chk("u4_sat", sat4, y[4]);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic s, input logic v, input logic e);
        if (sel == 0) begin start = s; valid = v; err = e; end
        else begin start4 = s; valid4 = v; err4 = e; end
    endtask

    task automatic start_pulse(input int sel, input logic v, input logic e);
        drive(sel, 1'b1, v, e);
        tick();
        drive(sel, 1'b0, 1'b0, 1'b0);
    endtask

    // Bit i is an error if i < first, or every>0 and i is the last of each group of 'every'.
    task automatic bits(input int sel, input int n, input int first, input int every, input int gap);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                drive(sel, 1'b0, 1'b0, 1'b0);
                repeat (gap) tick();
            end
            drive(sel, 1'b0, 1'b1, (i < first) || (every > 0 && (i % every) == every - 1));
            tick();
        end
        drive(sel, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input int sel, input int ec, input logic es);
        if (sel == 0) q0.push_back({es, 8'(ec)});
        else q4.push_back({es, 4'(ec)});
    endtask

    task automatic end_chk(input int sel);
        chk("done_after_last_bit", sel == 0 ? done : done4, 1);
        chk("busy_in_done", sel == 0 ? busy : busy4, 0);
    endtask

    task automatic frame(input int sel, input int n, input int first, input int every,
                         input int gap, input int ec, input logic es);
        push(sel, ec, es);
        start_pulse(sel, 1'b0, 1'b0);
        bits(sel, n, first, every, gap);
        end_chk(sel);
        tick();
        chk("done_one_cycle", sel == 0 ? done : done4, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_sat", sat, 0);
        chk("rst_alarm", alarm, 0);
        tick();
        rst_n = 1'b1;
        tick();
        drive(0, 1'b0, 1'b1, 1'b1);
        tick();
        chk("idle_ignores_valid", busy, 0);
        drive(0, 1'b0, 1'b0, 1'b0);

        frame(0, 64, 0, 0, 0, 0, 1'b0);
        frame(0, 64, 0, 4, 0, 16, 1'b0);
        frame(0, 64, 0, 4, 3, 16, 1'b0);

        frame(1, 32, 32, 0, 0, 15, 1'b1);
        frame(1, 32, 0, 0, 0, 0, 1'b0);
        frame(1, 32, 15, 0, 0, 15, 1'b0);

        push(0, 3, 1'b0);
        start_pulse(0, 1'b0, 1'b0);
        bits(0, 10, 10, 0, 0);
        chk("busy_mid_frame", busy, 1);
        start_pulse(0, 1'b1, 1'b1);
        chk("busy_after_restart", busy, 1);
        bits(0, 64, 3, 0, 0);
        end_chk(0);
        tick();

        push(0, 0, 1'b0);
        start_pulse(0, 1'b1, 1'b1);
        bits(0, 64, 0, 0, 0);
        end_chk(0);
        tick();

        frame(0, 64, 7, 0, 0, 7, 1'b0);
        chk("cnt_holds_idle", cnt, 7);
        start_pulse(0, 1'b0, 1'b0);
        chk("cnt_held_after_start", cnt, 7);
        bits(0, 30, 0, 2, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_cnt", cnt, 0);
        chk("async_rst_sat", sat, 0);
        chk("async_rst_cnt4", cnt4, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        frame(0, 64, 0, 8, 0, 8, 1'b0);

`ifdef ERR_ALARM_EN
        push(0, 4, 1'b0);
        start_pulse(0, 1'b0, 1'b0);
        bits(0, 64, 4, 0, 0);
        end_chk(0);
        chk("alarm_set_in_done", alarm, 1);
        tick();
        chk("alarm_sticky_idle", alarm, 1);
        push(0, 0, 1'b0);
        start_pulse(0, 1'b0, 1'b0);
        chk("alarm_cleared_by_start", alarm, 0);
        bits(0, 64, 0, 0, 0);
        end_chk(0);
        chk("alarm_zero_frame", alarm, 0);
        tick();
        push(0, 3, 1'b0);
        start_pulse(0, 1'b0, 1'b0);
        bits(0, 64, 3, 0, 0);
        end_chk(0);
        chk("alarm_below_thr", alarm, 0);
        tick();
`endif

        repeat (5) tick();
        chk("u0_queue_empty", q0.size(), 0);
        chk("u4_queue_empty", q4.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
